// File: rtl/img_pkg.sv
// img_pkg: shared types for the vsync/href/gray pixel bus
//   PIX_W   - gray pixel width
//   cnt_t   - 12-bit raster/timer count
//   state_t - raster FSM states
package img_pkg;
    localparam int PIX_W = 8;
    typedef logic [11:0] cnt_t;
    typedef enum logic [2:0] {IDLE, V_LEAD, ACTIVE, H_BLANK, V_TAIL} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered 1-cycle read data
//   clk, rst_n       - clock, async active-low reset (empties the buffer)
//   wr_en, din       - push request and data (ignored while full)
//   rd_en, dout      - pop request (ignored while empty), data valid the cycle after the pop
//   head             - combinational view of the oldest entry, used to inspect it before popping
//   full, empty      - status flags
//   data_count       - number of stored entries
module sync_fifo #(
    parameter int C_FIFO_WIDTH = 9,
    parameter int C_FIFO_DEPTH = 1024,
    localparam int AW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1,
    localparam int CW = $clog2(C_FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [C_FIFO_WIDTH-1:0] din,
    input  logic                    rd_en,
    output logic [C_FIFO_WIDTH-1:0] dout,
    output logic [C_FIFO_WIDTH-1:0] head,
    output logic                    full,
    output logic                    empty,
    output logic [CW-1:0]           data_count
);
    logic [C_FIFO_WIDTH-1:0] mem [C_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_wr, do_rd;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(C_FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full  = data_count == CW'(C_FIFO_DEPTH);
    assign empty = data_count == '0;
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout       <= '0;
            data_count <= '0;
        end else begin
            if (do_wr) wr_ptr <= nxt(wr_ptr);
            if (do_rd) begin
                rd_ptr <= nxt(rd_ptr);
                dout   <= mem[rd_ptr];
            end
            data_count <= data_count + CW'(do_wr) - CW'(do_rd);
        end
    end
endmodule

// File: rtl/img_stream_timing_gen.sv
// img_stream_timing_gen: buffers a valid/ready pixel stream and re-emits it on a fixed vsync/href raster
//   clk, rst_n                - clock, async active-low reset
//   s_valid, s_ready, s_data  - input pixel handshake (s_ready = buffer not full)
//   s_sof                     - input pixel is first of frame
//   tpg_en                    - only with IMG_TPG_EN defined: next frame is an internal (hcnt+vcnt) pattern
//   post_img_vsync/href/gray  - output raster, all three two cycles behind the FSM
//   frame_done                - pulse in the first vsync-low cycle after a frame
//   frame_err                 - pulse alongside a pixel that carried sof but was not first in the frame
module img_stream_timing_gen
    import img_pkg::*;
#(
    parameter cnt_t IMG_HDISP  = 12'd640,
    parameter cnt_t IMG_VDISP  = 12'd480,
    parameter cnt_t HBLANK     = 12'd10,
    parameter cnt_t VSYNC_LEAD = 12'd4,
    parameter cnt_t VSYNC_TAIL = 12'd700,
    parameter cnt_t VBLANK     = 12'd16,
    parameter int   FIFO_DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
`ifdef IMG_TPG_EN
    input  logic             tpg_en,
`endif
    output logic             post_img_vsync,
    output logic             post_img_href,
    output logic [PIX_W-1:0] post_img_gray,
    output logic             frame_done,
    output logic             frame_err
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t         state;
    cnt_t           hcnt, vcnt, tcnt, t_lim;
    logic [PIX_W:0] dout, head;
    logic [CW-1:0]  count;
    logic           full, empty, rd_en, line_ok, t_done, start_ok, tpg_frame;
    logic           vs_d1, href_d1, err_d1, tpg_d1;
    logic [PIX_W-1:0] pat_d1;

    sync_fifo #(
        .C_FIFO_WIDTH(PIX_W + 1),
        .C_FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (s_valid),
        .din        ({s_sof, s_data}),
        .rd_en      (rd_en),
        .dout       (dout),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .data_count (count)
    );

    assign s_ready = !full;
    // a whole line must be buffered before href starts so the burst never stalls
    assign line_ok = 32'(count) >= 32'(IMG_HDISP);
    assign t_lim   = state == IDLE ? VBLANK : state == V_LEAD ? VSYNC_LEAD :
                     state == H_BLANK ? HBLANK : VSYNC_TAIL;
    // tcnt saturates at t_lim-1, so this stays true until the state moves on
    assign t_done  = tcnt + 12'd1 >= t_lim;

`ifdef IMG_TPG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tpg_frame <= 1'b0;
        else if (state == IDLE) tpg_frame <= tpg_en;
    end
    assign start_ok = tpg_en || (head[PIX_W] && line_ok);
`else
    assign tpg_frame = 1'b0;
    assign start_ok  = head[PIX_W] && line_ok;
`endif

    // in IDLE anything at the head without sof is stale and dropped to resync on the next frame
    assign rd_en = (state == IDLE && !empty && !head[PIX_W]) || (state == ACTIVE && !tpg_frame);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hcnt  <= '0;
            vcnt  <= '0;
            tcnt  <= '0;
        end else begin
            tcnt <= t_done ? tcnt : tcnt + 12'd1;
            case (state)
                IDLE: if (t_done && start_ok) begin
                    state <= V_LEAD;
                    tcnt  <= '0;
                end
                V_LEAD: if (t_done) begin
                    state <= ACTIVE;
                    tcnt  <= '0;
                end
                ACTIVE: if (hcnt == IMG_HDISP - 12'd1) begin
                    hcnt  <= '0;
                    tcnt  <= '0;
                    vcnt  <= (vcnt == IMG_VDISP - 12'd1) ? '0 : vcnt + 12'd1;
                    state <= (vcnt == IMG_VDISP - 12'd1) ? V_TAIL : H_BLANK;
                end else begin
                    hcnt <= hcnt + 12'd1;
                end
                H_BLANK: if (t_done && (tpg_frame || line_ok)) begin
                    state <= ACTIVE;
                    tcnt  <= '0;
                end
                V_TAIL: if (t_done) begin
                    state <= IDLE;
                    tcnt  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // stage 1 aligns control with the FIFO read latency, stage 2 is the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1          <= 1'b0;
            href_d1        <= 1'b0;
            err_d1         <= 1'b0;
            tpg_d1         <= 1'b0;
            pat_d1         <= '0;
            post_img_vsync <= 1'b0;
            post_img_href  <= 1'b0;
            post_img_gray  <= '0;
            frame_done     <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            vs_d1          <= state != IDLE;
            href_d1        <= state == ACTIVE;
            err_d1         <= state == ACTIVE && !tpg_frame && (hcnt != '0 || vcnt != '0);
            tpg_d1         <= tpg_frame;
            pat_d1         <= hcnt[PIX_W-1:0] + vcnt[PIX_W-1:0];
            post_img_vsync <= vs_d1;
            post_img_href  <= href_d1;
            frame_done     <= post_img_vsync && !vs_d1;
            frame_err      <= err_d1 && dout[PIX_W];
            if (href_d1) post_img_gray <= tpg_d1 ? pat_d1 : dout[PIX_W-1:0];
        end
    end
endmodule

// File: tb/tb_img_stream_timing_gen.sv
// tb_img_stream_timing_gen: directed frame vectors plus back-to-back and mid-frame reset sequences
module tb_img_stream_timing_gen;
    logic       clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_sof = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_ready, post_img_vsync, post_img_href, frame_done, frame_err;
    logic [7:0] post_img_gray;

    always #5 clk = ~clk;

    img_stream_timing_gen #(
        .IMG_HDISP(12'd8), .IMG_VDISP(12'd4), .HBLANK(12'd4), .VSYNC_LEAD(12'd2),
        .VSYNC_TAIL(12'd10), .VBLANK(12'd6), .FIFO_DEPTH(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .post_img_vsync(post_img_vsync), .post_img_href(post_img_href),
        .post_img_gray(post_img_gray), .frame_done(frame_done), .frame_err(frame_err)
    );

    typedef struct {
        string name;
        int    junk;
        int    period;
        int    sof_at;
        int    base;
        int    exp_lead;
        int    exp_err;
    } vec_t;

    int n_tests = 0, n_fail = 0;

    int frames = 0, done_cnt = 0, stray = 0, lowcnt = 0, last_low = -1;
    int lead = 0, min_gap = 1000, gap = 0, href_run = 0;
    bit in_frame = 0, seen_href = 0, had_fall = 0, fall_done_ok = 0;
    logic [7:0] got[$];
    int bursts[$], errs[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0;
            href_run = 0;
            lowcnt   = 0;
            had_fall = 0;
        end else begin
            if (frame_done) done_cnt++;
            if (frame_err && !post_img_href) stray++;
            if (post_img_vsync && !in_frame) begin
                in_frame  = 1;
                seen_href = 0;
                lead      = 0;
                gap       = 0;
                href_run  = 0;
                min_gap   = 1000;
                last_low  = had_fall ? lowcnt : -1;
                got.delete();
                bursts.delete();
                errs.delete();
            end
            if (!post_img_vsync) begin
                if (in_frame) begin
                    in_frame     = 0;
                    frames++;
                    had_fall     = 1;
                    lowcnt       = 0;
                    fall_done_ok = frame_done;
                end
                lowcnt++;
            end
            if (in_frame) begin
                if (post_img_href) begin
                    seen_href = 1;
                    if (href_run == 0 && bursts.size() > 0 && gap < min_gap) min_gap = gap;
                    if (frame_err) errs.push_back(got.size());
                    got.push_back(post_img_gray);
                    href_run++;
                end else begin
                    if (href_run > 0) begin
                        bursts.push_back(href_run);
                        href_run = 0;
                        gap      = 0;
                    end
                    if (!seen_href) lead++;
                    else gap++;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic sof, input int period);
        repeat (period - 1) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        for (int w = 0; !s_ready && w < 1000; w++) @(negedge clk);
        if (!s_ready) chk("push_timeout", 0, 1);
    endtask

    task automatic idle_in();
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic send_frame(input int base, input int sof_at, input int period);
        for (int i = 0; i < 32; i++) push(8'(base + i), i == 0 || i == sof_at, period);
        idle_in();
    endtask

    task automatic wait_frames(input int target, input string name);
        int w = 0;
        while (frames < target && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_frame_end"}, int'(frames >= target), 1);
    endtask

    task automatic check_frame(input vec_t v, input int done_before);
        int bad_b = 0, bad_d = 0, err_idx;
        foreach (bursts[i]) if (bursts[i] != 8) bad_b++;
        bad_d = (got.size() != 32) ? 1 : 0;
        foreach (got[i]) if (got[i] != 8'(v.base + i)) bad_d++;
        err_idx = (errs.size() == 0) ? -1 : (errs.size() == 1) ? errs[0] : -2;
        chk({v.name, "_lead"}, lead, v.exp_lead);
        chk({v.name, "_nbursts"}, bursts.size(), 4);
        chk({v.name, "_burst_len_bad"}, bad_b, 0);
        chk({v.name, "_gap_ge_4"}, int'(min_gap >= 4), 1);
        chk({v.name, "_data_bad"}, bad_d, 0);
        chk({v.name, "_first_gray"}, (got.size() > 0) ? int'(got[0]) : -1, v.base);
        chk({v.name, "_err_idx"}, err_idx, v.exp_err);
        chk({v.name, "_done_at_fall"}, int'(fall_done_ok), 1);
        chk({v.name, "_done_count"}, done_cnt - done_before, 1);
    endtask

    vec_t vecs[4];

    initial begin
        vec_t v;
        int f0, d0, hi, w;
        vecs[0] = '{"basic",    0, 1, -1,   0, 2, -1};
        vecs[1] = '{"throttle", 0, 3, -1,  40, 2, -1};
        vecs[2] = '{"junk",     5, 1, -1, 100, 2, -1};
        vecs[3] = '{"sof_err",  0, 1, 12, 150, 2, 12};

        repeat (2) @(negedge clk);
        chk("rst_vsync", int'(post_img_vsync), 0);
        chk("rst_href", int'(post_img_href), 0);
        chk("rst_gray", int'(post_img_gray), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_ready", int'(s_ready), 1);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            f0 = frames;
            d0 = done_cnt;
            for (int i = 0; i < vecs[k].junk; i++) push(8'(200 + i), 1'b0, 1);
            send_frame(vecs[k].base, vecs[k].sof_at, vecs[k].period);
            wait_frames(f0 + 1, vecs[k].name);
            check_frame(vecs[k], d0);
        end

        f0 = frames;
        send_frame(10, -1, 1);
        send_frame(60, -1, 1);
        wait_frames(f0 + 2, "b2b");
        d0 = done_cnt - 1;
        chk("b2b_vsync_low", last_low, 6);
        v = '{"b2b_f2", 0, 1, -1, 60, 2, -1};
        check_frame(v, d0);

        f0 = frames;
        send_frame(30, -1, 1);
        w = 0;
        while (!(bursts.size() >= 2 && post_img_href) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("midrst_reached_line2", int'(bursts.size() >= 2 && post_img_href), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_vsync", int'(post_img_vsync), 0);
        chk("midrst_href", int'(post_img_href), 0);
        chk("midrst_gray", int'(post_img_gray), 0);
        chk("midrst_ready", int'(s_ready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (post_img_vsync) hi++;
        end
        chk("midrst_no_partial_vsync", hi, 0);
        chk("midrst_frame_dropped", frames - f0, 0);
        d0 = done_cnt;
        send_frame(77, -1, 1);
        wait_frames(f0 + 1, "after_rst");
        v = '{"after_rst", 0, 1, -1, 77, 2, -1};
        check_frame(v, d0);

        chk("stray_err", stray, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
